byte_data_memory: RTL and testbench
===================================

// Module: byte_data_memory
// PURPOSE
//  Byte-addressable, little-endian RV32 data memory for the LSU path. Successor to the flat word RAM.
//  Adds sized loads/stores (B/H/W), load sign/zero extension, per-byte write enables and misalignment faults.
//  Adds a registered read with a valid/ready request/response handshake, plus a saturating fault counter.
// PARAMETERS
//  BIT_WIDTH    32     word width in bits; must be 32 (the byte-lane logic is RV32-specific)
//  ENTRY_COUNT  1024   number of BIT_WIDTH words
//  ADDR_WIDTH   $clog2((BIT_WIDTH/8)*ENTRY_COUNT)   byte address width
//  FCNT_WIDTH   8      width of the fault counter
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  req_valid    in   1            request present
//  req_ready    out  1            block can accept a request this cycle
//  req_write    in   1            1=store, 0=load
//  req_size     in   2            0=byte, 1=half, 2=word, 3=illegal
//  req_unsigned in   1            load only: 1=zero-extend (LBU/LHU), 0=sign-extend
//  req_addr     in   ADDR_WIDTH   byte address
//  req_wdata    in   BIT_WIDTH    store data, right-justified (low bytes used)
//  rsp_valid    out  1            response held
//  rsp_ready    in   1            consumer takes the response
//  rsp_rdata    out  BIT_WIDTH    extended load data; 0 for stores and faults
//  rsp_fault    out  1            request was misaligned or illegal
//  fault_count  out  FCNT_WIDTH   saturating count of faulting requests
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_fault=0, fault_count=0.
//    RAM contents are not reset. No write occurs while rst=1.
//  - Reset mid-operation: any held response is dropped. A request presented during reset is not accepted.
//  - FSM has two states.
//    IDLE: req_ready=1.
//    RESP: rsp_valid=1; req_ready=rsp_ready, which gives back-to-back throughput of 1 per cycle.
//  - FSM transitions:
//    IDLE  --accept-->            RESP
//    RESP  --rsp_ready & accept-->  RESP
//    RESP  --rsp_ready & !accept--> IDLE
//    RESP  --!rsp_ready-->          RESP  (rsp_* held stable)
//  - accept = req_valid & req_ready. All outputs are registered.
//  - Load latency: rsp_valid rises on the edge that accepts the load, i.e. the response is visible the next cycle.
//  - Word index = req_addr[ADDR_WIDTH-1:2]; byte lane = req_addr[1:0].
//  - Fault on any of:
//    size=3;
//    size=1 with addr[0]=1;
//    size=2 with addr[1:0]!=0.
//    A faulting request still completes the handshake: rsp_fault=1, rsp_rdata=0, no RAM write.
//    fault_count increments and saturates at all-ones.
//  - Store: on the accept edge, write byte enables as follows.
//    B: lane addr[1:0] <= wdata[7:0]
//    H: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0]
//    W: all 4 lanes
//    Unselected bytes are unchanged. The response has rdata=0, fault=0.
//  - Load: read word, shift right by 8*addr[1:0], then mask to the access size.
//    If req_unsigned=0, sign-extend from bit 7 (B) or bit 15 (H). W ignores req_unsigned.
//  - Store then load, same word, consecutive accepts: the load returns the post-store data (write-first).
//  - Address wrap: none; ADDR_WIDTH exactly spans the RAM, so every address is in range.
// TESTING
//  - Reset: rst=1 mid-RESP with rsp_ready=0.
//    -> rsp_valid=0 and fault_count=0 immediately; req_ready=1 after release.
//  - SW 0xDEADBEEF @0x10, then LW @0x10.
//    -> rdata=0xDEADBEEF one cycle after the LW accept, fault=0.
//  - Byte/half extension, same word:
//    LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  - SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF. SH 0x1234 @0x12, then LW -> 0x123455EF.
//  - Faults:
//    LW @0x12, SH @0x11 and size=3 each -> fault=1, rdata=0, RAM unchanged, fault_count=3.
//    256 faults -> fault_count=0xFF.
//  - Backpressure:
//    hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0.
//    Streaming 8 loads with rsp_ready=1 -> 8 responses in 8 consecutive cycles, in order.

Source files
------------

// File: rtl/byte_data_memory.sv
// Byte-addressable little-endian RV32 data memory with sized loads/stores, misalignment faults,
// a registered valid/ready response and a saturating fault counter.
module byte_data_memory #(
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned ENTRY_COUNT = 1024,
  parameter int unsigned ADDR_WIDTH  = $clog2((BIT_WIDTH / 8) * ENTRY_COUNT),
  parameter int unsigned FCNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BIT_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_fault,
  output logic [FCNT_WIDTH-1:0] fault_count
);

  localparam int unsigned IdxWidth = ADDR_WIDTH - 2;

  typedef enum logic {StIdle, StResp} state_e;

  state_e                  state_q, state_d;
  logic [BIT_WIDTH-1:0]    rdata_q, rdata_d;
  logic                    fault_q;
  logic [FCNT_WIDTH-1:0]   fcnt_q;

  logic [BIT_WIDTH-1:0]    mem [ENTRY_COUNT];

  logic                    accept;
  logic                    fault;
  logic                    do_write;
  logic [IdxWidth-1:0]     idx;
  logic [1:0]              lane;
  logic [3:0]              be;
  logic [BIT_WIDTH-1:0]    wword;
  logic [BIT_WIDTH-1:0]    rword;
  logic [BIT_WIDTH-1:0]    shifted;
  logic [BIT_WIDTH-1:0]    ld_data;

  assign idx  = req_addr[ADDR_WIDTH-1:2];
  assign lane = req_addr[1:0];

  // Nothing is accepted while reset is asserted, so no RAM write can happen then.
  assign req_ready = ~rst & ((state_q == StIdle) | rsp_ready);
  assign accept    = req_valid & req_ready;
  assign do_write  = accept & req_write & ~fault;

  always_comb begin
    fault = 1'b0;
    be    = 4'b0000;
    wword = req_wdata;
    unique case (req_size)
      2'd0: begin
        be    = 4'b0001 << lane;
        wword = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        fault = req_addr[0];
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        fault = |req_addr[1:0];
        be    = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (req_size)
      2'd0: ld_data = req_unsigned ? {{(BIT_WIDTH-8){1'b0}}, shifted[7:0]}
                                   : {{(BIT_WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'd1: ld_data = req_unsigned ? {{(BIT_WIDTH-16){1'b0}}, shifted[15:0]}
                                   : {{(BIT_WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
    rdata_d = (req_write | fault) ? '0 : ld_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      StResp: if (rsp_ready) state_d = accept ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rdata_q <= '0;
      fault_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_q <= rdata_d;
        fault_q <= fault;
        if (fault && !(&fcnt_q)) fcnt_q <= fcnt_q + FCNT_WIDTH'(1);
      end
    end
  end

  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rdata_q;
  assign rsp_fault   = fault_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Scoreboard bench for byte_data_memory: byte-array reference model, queued expectations,
// independent response monitor.
module tb_byte_data_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [7:0]  fault_count;

  byte_data_memory dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem_m [4096];
  int          fcnt_m = 0;
  logic [32:0] exp_q [$];
  int          pop_cyc [$];
  bit          bp_mode  = 1'b0;
  bit          rsp_fixed = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, responses as {fault, rdata}.
  function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [11:0] a, input logic [31:0] wd);
    int          ai;
    logic        f;
    logic [31:0] d;
    ai = int'(a);
    f  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    d  = 32'd0;
    if (f) begin
      if (fcnt_m < 255) fcnt_m++;
    end else if (w) begin
      for (int i = 0; i < (1 << sz); i++) mem_m[ai + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < (1 << sz); i++) d[8*i +: 8] = mem_m[ai + i];
      if (!uns && sz == 2'd0) d = {{24{d[7]}}, d[7:0]};
      if (!uns && sz == 2'd1) d = {{16{d[15]}}, d[15:0]};
    end
    exp_q.push_back({f, d});
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] wd);
    int n = 0;
    bit done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    while (!done) begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        model(w, sz, uns, a, wd);
        done = 1'b1;
      end else if (n > 100) begin
        total++;
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        done = 1'b1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rsp_ready = bp_mode ? ($urandom_range(0, 3) != 0) : rsp_fixed;
    end
  end

  // Monitor: a response is consumed when valid and ready are both high going into the edge.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp: got rdata %h fault %b expected none", rsp_rdata,
                   rsp_fault);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {31'd0, rsp_fault, rsp_rdata}, {31'd0, e});
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [11:0] a;
    logic [32:0] held;
    int          r;

    #12;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_fault", rsp_fault, 0);
    chk("reset_fault_count", fault_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 1024; i++) issue(1'b1, 2'd2, 1'b0, 12'(i * 4), $urandom);
    drain();

    // Directed sized accesses on word 0x10.
    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 12'h012, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 12'h010, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 12'h011, 32'h00000055);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 12'h012, 32'h00001234);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 12'h012, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 12'h011, 32'hFFFFFFFF);
    issue(1'b1, 2'd3, 1'b0, 12'h010, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    drain();
    chk("fault_count_3", fault_count, 8'(fcnt_m));

    // Backpressure: response held for 5 cycles.
    rsp_fixed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_hold", {31'd0, rsp_fault, rsp_rdata}, {31'd0, held});
    end
    rsp_fixed = 1'b1;
    drain();

    // Streaming: 8 loads, one response per cycle.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) issue(1'b0, 2'd2, 1'b0, 12'(i * 4), 32'h0);
    drain();
    chk("stream_count", pop_cyc.size(), 8);
    for (int i = 1; i < pop_cyc.size(); i++) chk("stream_gap", pop_cyc[i] - pop_cyc[i-1], 1);

    // Random traffic with random backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 12'($urandom);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    bp_mode = 1'b0;
    drain();
    chk("fault_count_rand", fault_count, 8'(fcnt_m));

    for (int i = 0; i < 256; i++) issue(1'b0, 2'd3, 1'b0, 12'(i), 32'h0);
    drain();
    chk("fault_count_sat", fault_count, 8'hFF);

    // Reset while a faulting response is held; a request during reset must be ignored.
    rsp_fixed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    issue(1'b1, 2'd3, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_valid", rsp_valid, 0);
    chk("midreset_fault_count", fault_count, 0);
    chk("midreset_fault", rsp_fault, 0);
    exp_q.delete();
    fcnt_m = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 12'h010; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("release_ready", req_ready, 1);
    chk("release_valid", rsp_valid, 0);
    rsp_fixed = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
